// File: rtl/aes_inv_key_schedule.sv
// AES-128 reverse key schedule: walks round keys from round 10 down to round 0 over a valid/ready stream.
// Optional define AES_INV_KS_SBOX_REG_EN registers the SubWord result, which costs one extra cycle per key.
module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the most significant byte of the table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

`ifdef AES_INV_KS_SBOX_REG_EN
  typedef enum logic [1:0] {IDLE, EMIT, SBOX} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

  state_t        state_reg, state_next;
  logic [127:0]  key_reg, key_next;
  logic [3:0]    index_reg, index_next;
  logic          valid_reg, valid_next;
  logic          done_reg, done_next;

  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   v0, v1, v2, v3;
  logic [31:0]   rot_word, sub_word, sub_used;
  logic [7:0]    rcon;
  logic [127:0]  prev_key;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  assign v3 = w3 ^ w2;
  assign v2 = w2 ^ w1;
  assign v1 = w1 ^ w0;
  assign rot_word = {v3[23:0], v3[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
    end
  endgenerate

`ifdef AES_INV_KS_SBOX_REG_EN
  logic [31:0] sub_reg;

  // key_reg is frozen while in EMIT and SBOX, so sub_reg always matches the current key there.
  always_ff @(posedge clk) begin
    if (!rst_n) sub_reg <= '0;
    else        sub_reg <= sub_word;
  end
  assign sub_used = sub_reg;
`else
  assign sub_used = sub_word;
`endif

  always_comb begin
    case (index_reg)
      4'd10:   rcon = 8'h36;
      4'd9:    rcon = 8'h1b;
      4'd8:    rcon = 8'h80;
      4'd7:    rcon = 8'h40;
      4'd6:    rcon = 8'h20;
      4'd5:    rcon = 8'h10;
      4'd4:    rcon = 8'h08;
      4'd3:    rcon = 8'h04;
      4'd2:    rcon = 8'h02;
      4'd1:    rcon = 8'h01;
      default: rcon = 8'h00;
    endcase
  end

  assign v0 = w0 ^ sub_used ^ {rcon, 24'h0};
  assign prev_key = {v0, v1, v2, v3};

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    index_next = index_reg;
    valid_next = valid_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          key_next   = last_key;
          index_next = 4'd10;
          valid_next = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (valid_reg && rk_ready) begin
          if (index_reg == 4'd0) begin
            valid_next = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
`ifdef AES_INV_KS_SBOX_REG_EN
            valid_next = 1'b0;
            state_next = SBOX;
`else
            key_next   = prev_key;
            index_next = index_reg - 4'd1;
`endif
          end
        end
      end
`ifdef AES_INV_KS_SBOX_REG_EN
      SBOX: begin
        key_next   = prev_key;
        index_next = index_reg - 4'd1;
        valid_next = 1'b1;
        state_next = EMIT;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      index_reg <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      index_reg <= index_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

  assign rk_out   = key_reg;
  assign rk_index = index_reg;
  assign rk_valid = valid_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: FIPS-197 word-recurrence model with an algebraically derived S-box,
// a per-cycle compare process, and directed runs (A.1 vector, backpressure, start while busy, reset, round trip).
module tb_aes_inv_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
    .rk_out(rk_out), .rk_index(rk_index), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy), .done(done)
  );

`ifdef AES_INV_KS_SBOX_REG_EN
  localparam int START_TO_DONE = 22;
`else
  localparam int START_TO_DONE = 12;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_keys [11];
  int           exp_idx;
  bit           active, done_due, checking;
  logic [127:0] key0_seen;
  logic [127:0] prev_out;
  logic [3:0]   prev_index;
  bit           prev_stall;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_m[x] = s;
    end
  endtask

  function automatic logic [7:0] rcon_m(input int r);
    logic [7:0] c = 8'h01;
    for (int i = 1; i < r; i++) c = gmul(c, 8'h02);
    return c;
  endfunction

  function automatic logic [31:0] temp_m(input logic [31:0] w, input int r);
    logic [31:0] rw = {w[23:0], w[31:24]};
    return {sbox_m[rw[31:24]], sbox_m[rw[23:16]], sbox_m[rw[15:8]], sbox_m[rw[7:0]]} ^ {rcon_m(r), 24'h0};
  endfunction

  function automatic logic [127:0] forward_last(input logic [127:0] k);
    logic [31:0] w [44];
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++)
      w[i] = w[i-4] ^ ((i % 4 == 0) ? temp_m(w[i-1], i/4) : w[i-1]);
    return {w[40], w[41], w[42], w[43]};
  endfunction

  // Solve w[j] = w[j-4] ^ f(w[j-1]) backwards for w[j-4], j = 43 .. 4.
  task automatic model_inverse(input logic [127:0] lk);
    logic [31:0] w [44];
    for (int i = 0; i < 4; i++) w[40+i] = lk[127-32*i -: 32];
    for (int j = 43; j >= 4; j--)
      w[j-4] = w[j] ^ ((j % 4 == 0) ? temp_m(w[j-1], j/4) : w[j-1]);
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(negedge clk) begin
    if (checking && rst_n === 1'b1) begin
      chk("done", done, done_due);
      if (done_due) active = 0;
      done_due = 0;
      chk("busy", busy, active);
      if (prev_stall) begin
        chk("hold_valid", rk_valid, 1'b1);
        chk("hold_key", rk_out, prev_out);
        chk("hold_index", rk_index, prev_index);
      end
      prev_stall = rk_valid && !rk_ready;
      prev_out   = rk_out;
      prev_index = rk_index;
      if (!active) begin
        chk("idle_valid", rk_valid, 1'b0);
      end else if (rk_valid) begin
        chk("rk_index", rk_index, exp_idx);
        chk("rk_out", rk_out, exp_keys[exp_idx]);
        if (rk_ready) begin
          if (exp_idx == 0) begin
            key0_seen = rk_out;
            done_due  = 1;
          end else begin
            exp_idx--;
          end
        end
      end
    end else begin
      prev_stall = 0;
    end
  end

  // mode 0: ready high; 1: random ready; 2: ready high + start pulses while busy; 3: reset at index 6
  task automatic run(input logic [127:0] lk, input int mode, output int done_cyc);
    int cycles = 0;
    done_cyc = 0;
    model_inverse(lk);
    exp_idx  = 10;
    last_key = lk;
    start    = 1'b1;
    rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    active = 1;
    cycles = 1;
    while (active && cycles < 200) begin
      if (done && done_cyc == 0) done_cyc = cycles;
      if (mode == 1) rk_ready = 1'($urandom_range(0, 1));
      if (mode == 2 && rk_valid && (rk_index == 4'd5 || rk_index == 4'd0)) begin
        start    = 1'b1;
        last_key = ~lk;
      end else begin
        start = 1'b0;
      end
      if (mode == 3 && rk_valid && rk_index == 4'd6) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        active   = 0;
        done_due = 0;
        chk("rst_valid", rk_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out", rk_out, 128'h0);
        chk("rst_index", rk_index, 4'd0);
        chk("rst_done", done, 1'b0);
        return;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    if (cycles >= 200) chk("run_timeout", cycles, 0);
  endtask

  initial begin
    int dc;
    logic [127:0] k;
    logic [127:0] a1_last = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    logic [127:0] a1_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rst_n = 1'b0; start = 1'b1; last_key = a1_last; rk_ready = 1'b1;
    active = 0; done_due = 0; checking = 0; prev_stall = 0; exp_idx = 10;

    build_sbox();
    chk("model_sbox00", sbox_m[0], 8'h63);
    chk("model_sbox53", sbox_m[8'h53], 8'hed);
    model_inverse(a1_last);
    chk("model_k10", exp_keys[10], a1_last);
    chk("model_k9", exp_keys[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("model_k0", exp_keys[0], a1_key);
    chk("model_fwd", forward_last(a1_key), a1_last);

    // start held together with reset must be ignored
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", rk_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_index", rk_index, 4'd0);
    chk("reset_out", rk_out, 128'h0);
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 1'b0);
    checking = 1;

    run(a1_last, 0, dc);
    chk("a1_key0", key0_seen, a1_key);
    chk("start_to_done", dc, START_TO_DONE);
    chk("idle_after", busy, 1'b0);
    chk("out_retained", rk_out, a1_key);

    run(a1_last, 1, dc);
    chk("bp_key0", key0_seen, a1_key);

    run(a1_last, 2, dc);
    chk("inj_key0", key0_seen, a1_key);
    repeat (5) @(posedge clk);
    #1;

    run(a1_last, 3, dc);
    run(128'h0, 0, dc);
    chk("zero_key0", key0_seen, exp_keys[0]);
    chk("zero_timing", dc, START_TO_DONE);

    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run(forward_last(k), 0, dc);
      chk("roundtrip", key0_seen, k);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
